// File: rtl/tone_mapping_stretch.sv
// tone_mapping_stretch
//   Per-frame contrast stretch. Running min/max statistics are collected over
//   each frame (sop..eop). At eop a sequential restoring divider computes
//   recip = floor(2^(W_O+FRAC) / (max - min)) for every statistics set. The
//   result becomes pending and is swapped into the active set on the next sop.
//   Pixels are mapped through a 3-stage pipeline:
//   out = min(((clamp(data - min, 0, diff)) * recip) >> FRAC, 2^W_O - 1).
//
//   Configuration macro: TONE_MAPPING_SHARED_RANGE_EN
//     defined   - one min/max over all channels, one shared coefficient set
//     undefined - independent statistics and coefficients per channel
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   sop/eop    frame start / end, qualified by valid
//   valid      input beat qualifier
//   data       CH channels of W bits, channel c at [c*W +: W]
//   data_o     CH channels of W_O bits, channel c at [c*W_O +: W_O]
//   valid_o, sop_o, eop_o  sideband aligned with data_o (3-cycle latency)
//   coef_busy  high while the reciprocal FSM is not idle
module tone_mapping_stretch #(
    parameter int unsigned W    = 10,
    parameter int unsigned W_O  = 8,
    parameter int unsigned CH   = 3,
    parameter int unsigned FRAC = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sop,
    input  logic              eop,
    input  logic              valid,
    input  logic [CH*W-1:0]   data,
    output logic [CH*W_O-1:0] data_o,
    output logic              valid_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              coef_busy
);

`ifdef TONE_MAPPING_SHARED_RANGE_EN
    localparam int unsigned NS = 1;
`else
    localparam int unsigned NS = CH;
`endif
    localparam int unsigned QW = W_O + FRAC + 1;   // reciprocal width
    localparam int unsigned PW = W + QW;           // product width
    localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned BW = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [W-1:0]  DiffRst  = {W{1'b1}};
    localparam logic [QW-1:0] RecipRst =
        QW'((64'd1 << (W_O + FRAC)) / ((64'd1 << W) - 64'd1));

    typedef enum logic [1:0] {StIdle, StDiv, StStore} state_e;

    // Statistics set used by channel c.
    function automatic int unsigned sidx(input int unsigned c);
        return (NS == 1) ? 32'd0 : c;
    endfunction

    // ---------------- frame statistics ----------------
    logic [W-1:0] beat_min [NS];
    logic [W-1:0] beat_max [NS];
    logic [W-1:0] upd_min  [NS];
    logic [W-1:0] upd_max  [NS];
    logic [W-1:0] run_min_q [NS];
    logic [W-1:0] run_max_q [NS];

    always_comb begin
        for (int unsigned s = 0; s < NS; s++) begin
            beat_min[s] = '1;
            beat_max[s] = '0;
        end
        for (int unsigned c = 0; c < CH; c++) begin
            if (data[c*W +: W] < beat_min[sidx(c)]) beat_min[sidx(c)] = data[c*W +: W];
            if (data[c*W +: W] > beat_max[sidx(c)]) beat_max[sidx(c)] = data[c*W +: W];
        end
        // A sop beat reloads, so the eop latch below also covers one-beat frames.
        for (int unsigned s = 0; s < NS; s++) begin
            if (sop) begin
                upd_min[s] = beat_min[s];
                upd_max[s] = beat_max[s];
            end else begin
                upd_min[s] = (beat_min[s] < run_min_q[s]) ? beat_min[s] : run_min_q[s];
                upd_max[s] = (beat_max[s] > run_max_q[s]) ? beat_max[s] : run_max_q[s];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < NS; s++) begin
                run_min_q[s] <= '0;
                run_max_q[s] <= '0;
            end
        end else if (valid) begin
            for (int unsigned s = 0; s < NS; s++) begin
                run_min_q[s] <= upd_min[s];
                run_max_q[s] <= upd_max[s];
            end
        end
    end

    // ---------------- reciprocal FSM ----------------
    state_e        state_q;
    logic [CW-1:0] ch_q;
    logic [CW-1:0] ch_nxt;
    logic [BW-1:0] bit_cnt_q;
    logic [W-1:0]  rem_q;
    logic [QW-1:0] quo_q;
    logic [W-1:0]  calc_min_q    [NS];
    logic [W-1:0]  calc_diff_q   [NS];
    logic [QW-1:0] stage_recip_q [NS];
    logic [W-1:0]  pend_min_q    [NS];
    logic [W-1:0]  pend_diff_q   [NS];
    logic [QW-1:0] pend_recip_q  [NS];
    logic          pending_ok_q;
    logic          swap;

    logic [W:0]    div_shift;
    logic          div_ge;
    logic [W-1:0]  div_rem;
    logic [QW-1:0] store_val;

    assign ch_nxt = ch_q + 1'b1;
    assign swap   = valid & sop & pending_ok_q;

    // Numerator is a single 1 followed by zeros, so only the first step shifts in a 1.
    always_comb begin
        div_shift = {rem_q, (bit_cnt_q == '0)};
        div_ge    = div_shift >= {1'b0, calc_diff_q[ch_q]};
        div_rem   = div_ge ? W'(div_shift - {1'b0, calc_diff_q[ch_q]}) : div_shift[W-1:0];
        store_val = (calc_diff_q[ch_q] == '0) ? '0 : quo_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            ch_q         <= '0;
            bit_cnt_q    <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            pending_ok_q <= 1'b0;
            coef_busy    <= 1'b0;
            for (int unsigned s = 0; s < NS; s++) begin
                calc_min_q[s]    <= '0;
                calc_diff_q[s]   <= '0;
                stage_recip_q[s] <= '0;
                pend_min_q[s]    <= '0;
                pend_diff_q[s]   <= '0;
                pend_recip_q[s]  <= '0;
            end
        end else begin
            if (swap) pending_ok_q <= 1'b0;
            // eop starts a calculation, or aborts and restarts a running one.
            if (valid && eop) begin
                for (int unsigned s = 0; s < NS; s++) begin
                    calc_min_q[s]  <= upd_min[s];
                    calc_diff_q[s] <= upd_max[s] - upd_min[s];
                end
                ch_q      <= '0;
                bit_cnt_q <= '0;
                rem_q     <= '0;
                quo_q     <= '0;
                coef_busy <= 1'b1;
                state_q   <= (upd_max[0] == upd_min[0]) ? StStore : StDiv;
            end else begin
                case (state_q)
                    StIdle: state_q <= StIdle;
                    StDiv: begin
                        rem_q     <= div_rem;
                        quo_q     <= {quo_q[QW-2:0], div_ge};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BW'(QW - 1)) state_q <= StStore;
                    end
                    StStore: begin
                        stage_recip_q[ch_q] <= store_val;
                        if (ch_q == CW'(NS - 1)) begin
                            for (int unsigned s = 0; s < NS; s++) begin
                                pend_min_q[s]   <= calc_min_q[s];
                                pend_diff_q[s]  <= calc_diff_q[s];
                                pend_recip_q[s] <= (CW'(s) == ch_q) ? store_val : stage_recip_q[s];
                            end
                            pending_ok_q <= 1'b1;
                            coef_busy    <= 1'b0;
                            state_q      <= StIdle;
                        end else begin
                            ch_q      <= ch_nxt;
                            bit_cnt_q <= '0;
                            rem_q     <= '0;
                            quo_q     <= '0;
                            state_q   <= (calc_diff_q[ch_nxt] == '0) ? StStore : StDiv;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // ---------------- active coefficient set ----------------
    logic [W-1:0]  act_min_q   [NS];
    logic [W-1:0]  act_diff_q  [NS];
    logic [QW-1:0] act_recip_q [NS];
    logic [W-1:0]  eff_min     [NS];
    logic [W-1:0]  eff_diff    [NS];
    logic [QW-1:0] eff_recip   [NS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < NS; s++) begin
                act_min_q[s]   <= '0;
                act_diff_q[s]  <= DiffRst;
                act_recip_q[s] <= RecipRst;
            end
        end else if (swap) begin
            for (int unsigned s = 0; s < NS; s++) begin
                act_min_q[s]   <= pend_min_q[s];
                act_diff_q[s]  <= pend_diff_q[s];
                act_recip_q[s] <= pend_recip_q[s];
            end
        end
    end

    // The sop beat that triggers a swap is already processed with the new set.
    always_comb begin
        for (int unsigned s = 0; s < NS; s++) begin
            eff_min[s]   = swap ? pend_min_q[s]   : act_min_q[s];
            eff_diff[s]  = swap ? pend_diff_q[s]  : act_diff_q[s];
            eff_recip[s] = swap ? pend_recip_q[s] : act_recip_q[s];
        end
    end

    // ---------------- pixel pipeline ----------------
    logic [W-1:0]      s1_d       [CH];
    logic [W-1:0]      s1_d_q     [CH];
    logic [QW-1:0]     s1_recip_q [CH];
    logic [PW-1:0]     s2_p_q     [CH];
    logic [PW-1:0]     s3_sh      [CH];
    logic [CH*W_O-1:0] data_o_d;
    logic              s1_valid_q, s1_sop_q, s1_eop_q;
    logic              s2_valid_q, s2_sop_q, s2_eop_q;

    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            if (data[c*W +: W] < eff_min[sidx(c)]) begin
                s1_d[c] = '0;
            end else if (data[c*W +: W] - eff_min[sidx(c)] > eff_diff[sidx(c)]) begin
                s1_d[c] = eff_diff[sidx(c)];
            end else begin
                s1_d[c] = data[c*W +: W] - eff_min[sidx(c)];
            end
        end
    end

    always_comb begin
        data_o_d = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            s3_sh[c] = s2_p_q[c] >> FRAC;
            data_o_d[c*W_O +: W_O] = (|s3_sh[c][PW-1:W_O]) ? {W_O{1'b1}} : s3_sh[c][W_O-1:0];
        end
    end

    // Each beat carries its own recip so a swap cannot disturb beats in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sop_q   <= 1'b0;
            s2_eop_q   <= 1'b0;
            valid_o    <= 1'b0;
            sop_o      <= 1'b0;
            eop_o      <= 1'b0;
            data_o     <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
                s1_d_q[c]     <= '0;
                s1_recip_q[c] <= '0;
                s2_p_q[c]     <= '0;
            end
        end else begin
            s1_valid_q <= valid;
            s1_sop_q   <= valid & sop;
            s1_eop_q   <= valid & eop;
            s2_valid_q <= s1_valid_q;
            s2_sop_q   <= s1_sop_q;
            s2_eop_q   <= s1_eop_q;
            valid_o    <= s2_valid_q;
            sop_o      <= s2_sop_q;
            eop_o      <= s2_eop_q;
            data_o     <= data_o_d;
            for (int unsigned c = 0; c < CH; c++) begin
                s1_d_q[c]     <= s1_d[c];
                s1_recip_q[c] <= eff_recip[sidx(c)];
                s2_p_q[c]     <= PW'(s1_d_q[c]) * PW'(s1_recip_q[c]);
            end
        end
    end

endmodule

// File: doc/tone_mapping_stretch.md
TONE_MAPPING_STRETCH -- requirements
Module: tone_mapping_stretch

Interface
REQ-001 Parameter W, default 10, input component width.
REQ-002 Parameter W_O, default 8, output component width.
REQ-003 Parameter CH, default 3, channels per beat.
REQ-004 Parameter FRAC, default 16, reciprocal fraction bits.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 sop, eop, valid  input  1 each  frame start, frame end, beat qualifier; sop/eop meaningful only with valid.
REQ-008 data  input  CH*W  channel c at bits [c*W +: W].
REQ-009 data_o  output  CH*W_O  stretched pixel, channel c at [c*W_O +: W_O].
REQ-010 valid_o, sop_o, eop_o  output  1 each  valid/sop/eop delayed to align with data_o.
REQ-011 coef_busy  output  1  high while the reciprocal FSM is not IDLE.

Function
REQ-012 Per channel, running min/max SHALL reload from the data on a valid sop beat and update on every other valid beat.
REQ-013 On a valid eop beat, final min and diff=max-min per channel (including that beat) SHALL be latched into a calc set and the FSM started.
REQ-014 FSM states: IDLE, DIV, STORE; IDLE->DIV on eop; DIV runs W_O+FRAC+1 cycles, one restoring-division bit per cycle, then ->STORE; STORE writes pending min/recip for channel c, then ->DIV for c+1, or ->IDLE after channel CH-1 with pending_ok set.
REQ-015 recip SHALL be floor(2^(W_O+FRAC)/diff), width W_O+FRAC+1; diff==0 SHALL skip DIV and store recip=0.
REQ-016 Calc length: CH*(W_O+FRAC+2) cycles from eop (78 at defaults).
REQ-017 A valid eop during DIV/STORE SHALL abort, discard the partial result, relatch, and restart at channel 0; pending_ok unchanged.
REQ-018 On a valid sop with registered pending_ok=1, active min/recip SHALL take the pending set before that beat is processed, and pending_ok clears; with pending_ok=0 the active set is kept.
REQ-019 Pixel path: stage1 d=data-min clamped to [0,diff_active]; stage2 p=d*recip; stage3 data_o=min(p>>FRAC, 2^W_O-1).
REQ-020 Latency SHALL be exactly 3 cycles, data and sideband aligned; one beat per cycle; no backpressure.
REQ-021 sop and eop on the same beat form a one-pixel frame: swap per REQ-018, then calc with diff=0.
REQ-022 A second sop without an intervening eop SHALL restart accumulation with no calc start.

Reset
REQ-023 Reset SHALL clear data_o, valid_o, sop_o, eop_o, coef_busy, pending_ok and the pipeline; FSM->IDLE.
REQ-024 Reset active set per channel: min=0, diff=2^W-1, recip=floor(2^(W_O+FRAC)/(2^W-1)), an identity-range stretch.
REQ-025 Reset mid-calc or mid-frame SHALL discard all state; the first post-reset frame uses the reset set.

Configuration
REQ-026 Macro TONE_MAPPING_SHARED_RANGE_EN defined: one min/max over all channels, one division (W_O+FRAC+2 cycles), shared coefficients preserving colour balance.
REQ-027 Macro undefined: independent per-channel statistics and coefficients per REQ-012..REQ-018.

Verification
REQ-028 Reset, then frame with data 0 and 1023 (CH=1) -> data_o 0 and 255, valid_o 3 cycles after valid.
REQ-029 Frame min 100, max 355, 100-cycle blanking, next frame pixels 100/228/355/50/600 -> 0/128/255/0/255; recip 65793.
REQ-030 Same stats, blanking 10 cycles -> frame N+1 uses old coefficients, frame N+2 uses new; coef_busy high 78 cycles (CH=3).
REQ-031 Constant-value frame (diff 0) -> following frame all data_o 0; STORE reached without DIV.
REQ-032 Two 20-beat frames back-to-back -> second eop aborts calc, restart visible on coef_busy, only final stats applied.
REQ-033 Assert reset_n low during DIV -> all outputs 0 next edge; subsequent frame uses reset coefficients.
